// File: rtl/sseg_pkg.sv
// Shared types, segment constants and helpers for the seven-segment scan controller.
// Segments are active-low, bit 0 = segment a ... bit 6 = segment g.
package sseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Decimal digits needed for a bin_w-bit value: ceil(bin_w * log10(2)).
  function automatic int bcd_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

  // BCD nibble to active-low segment pattern; non-decimal codes stay dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sseg_bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep, last-wins pending slot.
// One bit is consumed per cycle; o_commit marks the cycle in which o_digits
// and o_overflow hold the finished result.
module sseg_bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int BIN_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      i_value,
  input  logic                  i_value_valid,
  output logic                  o_busy,
  output logic                  o_commit,
  output logic [N_DIGITS*4-1:0] o_digits,
  output logic                  o_overflow
);

  localparam int D_TOT = bcd_digits(BIN_W);
  // Accumulator is never narrower than the display, so small BIN_W still works.
  localparam int ACC_D = (D_TOT > N_DIGITS) ? D_TOT : N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_e             r_state;
  conv_state_e             w_state_nxt;
  logic [BIN_W-1:0]        r_bin;
  logic [ACC_D*4-1:0]      r_bcd;
  logic [ACC_D*4-1:0]      w_bcd_adj;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_pend_vld;
  logic [BIN_W-1:0]        r_pend_val;
  logic                    w_load;
  logic [BIN_W-1:0]        w_load_val;
  logic                    w_shift;
  logic                    w_commit;
  logic                    w_overflow;

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = r_pend_val;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_value_valid) begin
          w_load      = 1'b1;
          w_load_val  = i_value;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_bit_cnt == CNT_W'(BIN_W - 1)) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        // A strobe landing in this very cycle is newer than the pending slot.
        if (r_pend_vld || i_value_valid) begin
          w_load      = 1'b1;
          w_load_val  = i_value_valid ? i_value : r_pend_val;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Add-3 correction on every nibble of 5 or more, ahead of the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < ACC_D; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Overflow: any accumulated digit beyond the displayed ones is nonzero.
  always_comb begin
    w_overflow = 1'b0;
    for (int i = N_DIGITS; i < ACC_D; i++) begin
      if (r_bcd[i*4 +: 4] != 4'd0) w_overflow = 1'b1;
    end
  end

  // Shift datapath: load clears the accumulator, each shift moves one binary bit in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_bin     <= w_load_val;
      r_bcd     <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_bin     <= r_bin << 1;
      r_bcd     <= {w_bcd_adj[ACC_D*4-2:0], r_bin[BIN_W-1]};
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  // Pending slot: captures strobes while busy, consumed by the next reload.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the pending value is reset too, so a reset mid-conversion cannot replay a stale strobe.
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_val <= '0;
    end else if (w_load) begin
      r_pend_vld <= 1'b0;
    end else if (i_value_valid && (r_state != ST_IDLE)) begin
      r_pend_vld <= 1'b1;
      r_pend_val <= i_value;
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_commit   = w_commit;
  assign o_digits   = r_bcd[N_DIGITS*4-1:0];
  assign o_overflow = w_overflow;

endmodule

// File: rtl/sseg_scan_controller.sv
// Seven-segment scan controller: binary value -> BCD -> multiplexed common-anode display.
// Optional build macro SSEG_LZ_BLANK_EN enables leading-zero blanking.
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int BIN_W       = 32,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    value,
  input  logic                value_valid,
  output logic                busy,
  output logic                overflow,
  output logic [6:0]          sseg,
  output logic [N_DIGITS-1:0] an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                  w_commit;
  logic [N_DIGITS*4-1:0] w_digits;
  logic                  w_overflow;
  logic [N_DIGITS*4-1:0] r_disp;
  logic                  r_overflow;
  logic [CNT_W-1:0]      r_ref_cnt;
  logic [IDX_W-1:0]      r_scan_idx;
  logic [N_DIGITS-1:0]   w_lz;
  logic [6:0]            w_seg_cur;
  logic [6:0]            r_sseg;
  logic [N_DIGITS-1:0]   r_an;

  sseg_bin2bcd_seq #(
    .N_DIGITS (N_DIGITS),
    .BIN_W    (BIN_W)
  ) u_conv (
    .clk           (clk),
    .rst           (rst),
    .i_value       (value),
    .i_value_valid (value_valid),
    .o_busy        (busy),
    .o_commit      (w_commit),
    .o_digits      (w_digits),
    .o_overflow    (w_overflow)
  );

  // Display register: whole value replaced in one cycle, never partially.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp     <= '0;
      r_overflow <= 1'b0;
    end else if (w_commit) begin
      r_disp     <= w_digits;
      r_overflow <= w_overflow;
    end
  end

  // Refresh divider and scan index, free-running regardless of conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_cnt  <= '0;
      r_scan_idx <= '0;
    end else if (r_ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      r_ref_cnt  <= '0;
      r_scan_idx <= (r_scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_scan_idx + IDX_W'(1);
    end else begin
      r_ref_cnt  <= r_ref_cnt + CNT_W'(1);
    end
  end

  // Leading-zero mask: digit i is blanked when it and all digits above are zero.
  always_comb begin : p_lz
    logic zero_run;
    w_lz     = '0;
    zero_run = 1'b1;
`ifdef SSEG_LZ_BLANK_EN
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (r_disp[i*4 +: 4] == 4'd0);
      w_lz[i]  = zero_run;
    end
`endif
  end

  // Segment pattern for the digit currently selected by the scan index.
  always_comb begin
    if (r_overflow)          w_seg_cur = SEG_DASH;
    else if (w_lz[r_scan_idx]) w_seg_cur = SEG_BLANK;
    else                     w_seg_cur = bcd_to_seg(r_disp[r_scan_idx*4 +: 4]);
  end

  // Output registers: segments and anode enable change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sseg <= SEG_BLANK;
      r_an   <= '1;
    end else begin
      r_sseg <= w_seg_cur;
      r_an   <= ~(N_DIGITS'(1) << r_scan_idx);
    end
  end

  assign overflow = r_overflow;
  assign sseg     = r_sseg;
  assign an       = r_an;

endmodule
